// File: rtl/sliding_window_sequence_generator_pkg.sv
// Shared pattern definitions and FSM state type for the sliding-window sequence
// generator and its matching detector.
package sws_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        REP  = 2'd2,
        TAIL = 2'd3
    } state_t;

    localparam logic [3:0] HDR_PATTERN = 4'b1110;
    localparam int         HDR_LEN     = 4;
    localparam logic [1:0] REP_PATTERN = 2'b01;
    localparam logic       TAIL_BIT    = 1'b1;

endpackage

// File: rtl/sliding_window_sequence_generator_if.sv
// Frame request / serial output bundle of the sequence generator.
// err_inj exists only when SWSG_ERR_INJ_EN is defined.
interface sliding_window_sequence_generator_if #(
    parameter int REP_W = 4
);
    import sws_pkg::*;

    // start is sampled on every posedge but only takes effect while busy=0 or
    // in the tail cycle (done=1); otherwise it is dropped, never queued.
    // rep_cnt/err_inj are captured on the accepting edge; done pulses with the tail bit.
    logic             start;
    logic [REP_W-1:0] rep_cnt;
`ifdef SWSG_ERR_INJ_EN
    logic             err_inj;
`endif
    logic             out;
    logic             valid;
    logic             busy;
    logic             done;
    state_t           dbg_state;

    modport master (
        output start,
        output rep_cnt,
`ifdef SWSG_ERR_INJ_EN
        output err_inj,
`endif
        input  out,
        input  valid,
        input  busy,
        input  done,
        input  dbg_state
    );

    modport slave (
        input  start,
        input  rep_cnt,
`ifdef SWSG_ERR_INJ_EN
        input  err_inj,
`endif
        output out,
        output valid,
        output busy,
        output done,
        output dbg_state
    );

endinterface

// File: rtl/sliding_window_sequence_generator.sv
// Bit-serial frame generator: header 1110, N x "01", tail 1 (tail 0 when
// SWSG_ERR_INJ_EN is defined and err_inj was latched high).
module sliding_window_sequence_generator
    import sws_pkg::*;
#(
    parameter int REP_W = 4
) (
    input logic clk,
    input logic rst_n,
    sliding_window_sequence_generator_if.slave bus
);

    localparam logic [1:0]       HDR_LAST = 2'(HDR_LEN - 1);
    localparam logic [REP_W-1:0] CNT_ONE  = {{(REP_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_n;
    logic [1:0]       idx_q, idx_n;
    logic             phase_q, phase_n;
    logic [REP_W-1:0] cnt_q, cnt_n;
    logic [REP_W-1:0] n_q, n_n;
    logic             err_q, err_n;
    logic             accept;
    logic             out_q, out_n;
    logic             active_q, active_n;
    logic             done_q, done_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            phase_q  <= 1'b0;
            cnt_q    <= '0;
            n_q      <= '0;
            err_q    <= 1'b0;
            out_q    <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            idx_q    <= idx_n;
            phase_q  <= phase_n;
            cnt_q    <= cnt_n;
            n_q      <= n_n;
            err_q    <= err_n;
            out_q    <= out_n;
            active_q <= active_n;
            done_q   <= done_n;
        end
    end

    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        phase_n = phase_q;
        cnt_n   = cnt_q;
        n_n     = n_q;
        err_n   = err_q;
        accept  = 1'b0;

        unique case (state_q)
            IDLE: accept = bus.start;
            HDR: begin
                if (idx_q == HDR_LAST) begin
                    state_n = REP;
                    cnt_n   = n_q;
                    phase_n = 1'b0;
                end else begin
                    idx_n = idx_q + 2'd1;
                end
            end
            REP: begin
                // The repetition counter only moves on the '1' half of each pair.
                if (!phase_q) begin
                    phase_n = 1'b1;
                end else begin
                    phase_n = 1'b0;
                    cnt_n   = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) state_n = TAIL;
                end
            end
            TAIL: begin
                state_n = IDLE;
                accept  = bus.start;
            end
            default: state_n = IDLE;
        endcase

        if (accept) begin
            state_n = HDR;
            idx_n   = 2'd0;
            n_n     = (bus.rep_cnt == '0) ? CNT_ONE : bus.rep_cnt;
`ifdef SWSG_ERR_INJ_EN
            err_n   = bus.err_inj;
`else
            err_n   = 1'b0;
`endif
        end

        // Outputs are decoded from the next state so they leave a flop directly.
        active_n = (state_n != IDLE);
        done_n   = (state_n == TAIL);
        unique case (state_n)
            HDR:     out_n = HDR_PATTERN[~idx_n];
            REP:     out_n = REP_PATTERN[~phase_n];
            TAIL:    out_n = TAIL_BIT ^ err_n;
            default: out_n = 1'b0;
        endcase
    end

    assign bus.out       = out_q;
    assign bus.valid     = active_q;
    assign bus.busy      = active_q;
    assign bus.done      = done_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_sliding_window_sequence_generator.sv
// Self-checking bench for sliding_window_sequence_generator; exercises err_inj
// frames too when SWSG_ERR_INJ_EN is defined.
module tb_sliding_window_sequence_generator;
    import sws_pkg::*;

    localparam int REP_W = 4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    // Expected per-cycle entry: {done, out}; valid and busy are implied high.
    logic [1:0] exp_q[$];

    sliding_window_sequence_generator_if #(.REP_W(REP_W)) bus ();

    sliding_window_sequence_generator #(.REP_W(REP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference frame: header 1110, N pairs of 0 then 1, tail 1 (0 if corrupted).
    function automatic void model_push(input int n, input bit err);
        int eff;
        eff = (n == 0) ? 1 : n;
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b00);
        for (int r = 0; r < eff; r++) begin
            exp_q.push_back(2'b00);
            exp_q.push_back(2'b01);
        end
        exp_q.push_back({1'b1, ~err});
    endfunction

    task automatic drive_req(input int n, input bit err);
        bus.start   = 1'b1;
        bus.rep_cnt = n[REP_W-1:0];
`ifdef SWSG_ERR_INJ_EN
        bus.err_inj = err;
`else
        if (err) $display("note: err_inj ignored in this build");
`endif
    endtask

    task automatic check_idle(input string name);
        n_cmp++;
        if ({bus.out, bus.valid, bus.busy, bus.done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL %s: out/valid/busy/done=%b required 0000", name,
                     {bus.out, bus.valid, bus.busy, bus.done});
        end
    endtask

    // Checks one frame bit; the caller has already popped the expected entry.
    task automatic check_bit(input string name, input int k, input logic [1:0] e);
        n_cmp++;
        if ({bus.out, bus.valid, bus.busy, bus.done} !== {e[0], 1'b1, 1'b1, e[1]}) begin
            n_fail++;
            $display("FAIL %s bit %0d: out/valid/busy/done=%b required %b", name, k,
                     {bus.out, bus.valid, bus.busy, bus.done}, {e[0], 1'b1, 1'b1, e[1]});
        end
    endtask

    task automatic run_frame(input string name, input int n, input bit err, input bit noisy);
        int len;
        logic [1:0] e;
        @(negedge clk);
        drive_req(n, err);
        model_push(n, err);
        len = exp_q.size();
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.rep_cnt = REP_W'($urandom);
`ifdef SWSG_ERR_INJ_EN
        bus.err_inj = ~err;
`endif
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check_bit(name, k, e);
            // Start pulses before the tail edge must be ignored; none on the tail edge.
            bus.start = (noisy && k != len - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        @(negedge clk);
        check_idle({name, " after"});
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.rep_cnt = '0;
`ifdef SWSG_ERR_INJ_EN
        bus.err_inj = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_idle("reset_outputs");
        n_cmp++;
        if (bus.dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d required %0d", bus.dbg_state, IDLE);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("post_reset_idle");
    endtask

    task automatic test_basic();
        run_frame("n1", 1, 1'b0, 1'b0);
        run_frame("n3", 3, 1'b0, 1'b0);
        run_frame("n0", 0, 1'b0, 1'b0);
        run_frame("nmax", 15, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            run_frame("rand", int'($urandom_range(0, 15)), 1'b0, 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int len1, len;
        logic [1:0] e;
        exp_q.delete();
        model_push(1, 1'b0);
        len1 = exp_q.size();
        model_push(2, 1'b0);
        len = exp_q.size();
        @(negedge clk);
        drive_req(1, 1'b0);
        @(posedge clk);
        #1;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check_bit("b2b", k, e);
            if (k == 2) bus.rep_cnt = 4'd2;
            if (k == len1) bus.start = 1'b0;
        end
        @(negedge clk);
        check_idle("b2b after");
    endtask

    task automatic test_mid_reset();
        logic [1:0] e;
        exp_q.delete();
        model_push(2, 1'b0);
        @(negedge clk);
        drive_req(2, 1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check_bit("pre_abort", k, e);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("abort_async");
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check_idle("abort_hold");
        end
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_idle("abort_release");
        run_frame("after_abort", 1, 1'b0, 1'b0);
    endtask

`ifdef SWSG_ERR_INJ_EN
    task automatic test_err_inj();
        run_frame("err_n1", 1, 1'b1, 1'b0);
        run_frame("err_rand", int'($urandom_range(1, 15)), 1'b1, 1'b1);
        run_frame("clean_after_err", 2, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_basic();
        test_random();
        test_back_to_back();
        test_mid_reset();
`ifdef SWSG_ERR_INJ_EN
        test_err_inj();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
